victim_writeback_buffer: RTL and testbench
==========================================

// Module: victim_writeback_buffer
// PURPOSE
//   Write-side partner of the victim tag compare. Accepts dirty lines evicted by the L1 cache
//   and drains them to physical memory in FIFO order.
//   Exposes a tag lookup so the L1 miss path can take a line still in the buffer
//   instead of reading stale data from pmem. Sits between the L1 cache datapath and the pmem port.
// PARAMETERS
//   DEPTH       4    number of buffered lines (power of 2, >=2)
//   TAG_WIDTH   12   line tag width, address[15:4] (victim_tag)
//   LINE_WIDTH  128  cache line width in bits (lc3b_c_line)
// PORTS
//   clk           in   1           rising-edge clock
//   rst           in   1           synchronous active-high reset
//   evict_write   in   1           L1 offers an evicted dirty line this cycle
//   evict_tag     in   TAG_WIDTH   tag of the offered line
//   evict_data    in   LINE_WIDTH  data of the offered line
//   evict_ready   out  1           buffer can accept an offer this cycle
//   lookup_tag    in   TAG_WIDTH   tag probed by the L1 miss path
//   lookup_hit    out  1           a buffered entry matches lookup_tag
//   lookup_data   out  LINE_WIDTH  data of the matching entry (0 when no hit)
//   pmem_address  out  16          {head tag, 4'b0000}
//   pmem_wdata    out  LINE_WIDTH  head entry data
//   pmem_write    out  1           write request to pmem
//   pmem_resp     in   1           pmem write complete
// BEHAVIOUR
//   Reset: count=0, all valid bits clear, FSM=IDLE.
//     Outputs: evict_ready=1, lookup_hit=0, lookup_data=0, pmem_write=0, pmem_address=0, pmem_wdata=0.
//   Storage: circular FIFO with head/tail pointers (log2 DEPTH bits, wrap modulo DEPTH).
//     count is $clog2(DEPTH+1) bits.
//   evict_ready = (count < DEPTH), taken from registered count.
//     No full-cycle bypass: a pop at full does not allow a same-cycle push.
//   Push: on evict_write && evict_ready, at the clock edge.
//     - evict_tag matches a valid entry not in flight: overwrite that entry's data in place;
//       count and order unchanged.
//     - Otherwise write at tail, tail+1, count+1.
//     - evict_write while !evict_ready is ignored; the L1 holds its offer.
//   FSM IDLE: pmem_write=0; if count>0, next state WRITE.
//   FSM WRITE: pmem_write=1.
//     - pmem_address and pmem_wdata come from the head entry; they are registered at entry
//       to WRITE and held stable until pmem_resp.
//     - On pmem_resp: clear head valid, head+1, count-1, next state IDLE.
//     - This gives one idle bubble cycle between writebacks.
//   In-flight entry = head while in WRITE. A push whose tag matches it appends a new entry
//     and does not overwrite, so pmem never sees data change mid-request.
//   Push and pop in the same cycle: count unchanged, both pointers advance.
//   Lookup is combinational over all valid entries, the in-flight head included until popped.
//     - Multiple matches: the youngest (closest to tail) wins.
//     - No forwarding from a same-cycle push: lookup reflects pre-edge contents.
//   Reset asserted in WRITE: next cycle pmem_write=0 and all entries are dropped.
//     A late pmem_resp while IDLE with count=0 is ignored.
//   pmem_resp while IDLE is ignored.
// TESTING
//   1. Reset, push tag 0x123 data D0, pmem_resp 3 cycles after pmem_write rises.
//      -> pmem_address=0x1230, pmem_wdata=D0 stable until resp; count back to 0; evict_ready=1.
//   2. Four pushes (tags 0x001..0x004) with pmem_resp held low.
//      -> evict_ready=0 after the 4th; a 5th push is ignored.
//      -> Drain order is 0x0010, 0x0020, 0x0030, 0x0040.
//   3. Push 0x00A/D1, then 0x00B/D2, then 0x00B/D3 before any drain.
//      -> count=2; lookup 0x00B gives hit=1, data D3; pmem sees D3 for 0x00B0.
//   4. While 0x00A is in flight, push 0x00A/D4.
//      -> pmem_wdata stays D1; count=2; lookup 0x00A returns D4; second write carries D4.
//   5. At full, drive pmem_resp and evict_write in the same cycle.
//      -> The push is rejected that cycle and accepted the next (evict_ready=1); no entry is lost.
//   6. Assert rst during WRITE with count=3.
//      -> Next cycle pmem_write=0, lookup_hit=0 for all prior tags, evict_ready=1.

Source files
------------

// File: rtl/victim_writeback_buffer.sv
// victim_writeback_buffer
// Holds dirty lines evicted by the L1 and writes them back to pmem in FIFO
// order. The L1 miss path can look up a tag and take a line that is still
// buffered, so it never reads stale data from pmem.
module victim_writeback_buffer #(
    parameter int DEPTH      = 4,
    parameter int TAG_WIDTH  = 12,
    parameter int LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  evict_write,
    input  logic [TAG_WIDTH-1:0]  evict_tag,
    input  logic [LINE_WIDTH-1:0] evict_data,
    output logic                  evict_ready,
    input  logic [TAG_WIDTH-1:0]  lookup_tag,
    output logic                  lookup_hit,
    output logic [LINE_WIDTH-1:0] lookup_data,
    output logic [15:0]           pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    output logic                  pmem_write,
    input  logic                  pmem_resp
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t                state;
    state_t                next_state;

    logic [TAG_WIDTH-1:0]  tags [DEPTH];
    logic [LINE_WIDTH-1:0] lines [DEPTH];
    logic [DEPTH-1:0]      valid;
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [CNT_W-1:0]      count;

    logic [15:0]           addr_reg;
    logic [LINE_WIDTH-1:0] wdata_reg;

    logic                  overwrite_hit;
    logic [PTR_W-1:0]      overwrite_idx;
    logic [PTR_W-1:0]      lookup_idx;
    logic                  push;
    logic                  push_append;
    logic                  pop;
    logic                  load;
    logic [LINE_WIDTH-1:0] head_line;

    assign evict_ready  = (count < CNT_W'(DEPTH));
    assign push         = evict_write && evict_ready;
    assign push_append  = push && !overwrite_hit;
    assign pop          = (state == WRITE) && pmem_resp;
    assign load         = (state == IDLE) && (count != '0);
    assign pmem_address = addr_reg;
    assign pmem_wdata   = wdata_reg;

    // Find a buffered entry an incoming eviction may overwrite in place; the in-flight head is excluded
    always_comb begin
        overwrite_hit = 1'b0;
        overwrite_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (tags[i] == evict_tag) &&
                !((state == WRITE) && (PTR_W'(i) == head))) begin
                overwrite_hit = 1'b1;
                overwrite_idx = PTR_W'(i);
            end
        end
    end

    // Tag lookup walking from oldest to youngest so the youngest match wins
    always_comb begin
        lookup_hit  = 1'b0;
        lookup_data = '0;
        lookup_idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            lookup_idx = head + PTR_W'(k);
            if (valid[lookup_idx] && (tags[lookup_idx] == lookup_tag)) begin
                lookup_hit  = 1'b1;
                lookup_data = lines[lookup_idx];
            end
        end
    end

    // Head data captured on entry to WRITE, including a same-edge in-place overwrite of the head
    always_comb begin
        head_line = lines[head];
        if (push && overwrite_hit && (overwrite_idx == head)) begin
            head_line = evict_data;
        end
    end

    // Entry storage, pointers, occupancy and the registered pmem request
    always_ff @(posedge clk) begin
        if (rst) begin
            valid     <= '0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            addr_reg  <= '0;
            wdata_reg <= '0;
        end else begin
            if (push) begin
                if (overwrite_hit) begin
                    lines[overwrite_idx] <= evict_data;
                end else begin
                    tags[tail]  <= evict_tag;
                    lines[tail] <= evict_data;
                    valid[tail] <= 1'b1;
                    tail        <= tail + PTR_W'(1);
                end
            end
            if (pop) begin
                valid[head] <= 1'b0;
                head        <= head + PTR_W'(1);
                addr_reg    <= '0;
                wdata_reg   <= '0;
            end
            if (load) begin
                addr_reg  <= 16'({tags[head], 4'b0000});
                wdata_reg <= head_line;
            end
            case ({push_append, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Writeback FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Writeback FSM next state and pmem request strobe
    always_comb begin
        next_state = state;
        pmem_write = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    next_state = WRITE;
                end
            end
            WRITE: begin
                pmem_write = 1'b1;
                if (pmem_resp) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_victim_writeback_buffer.sv
// tb_victim_writeback_buffer
// Directed bench with a scoreboard queue of expected writebacks; lookups and
// evict_ready are predicted from the same queue.
module tb_victim_writeback_buffer;

    logic         clk = 1'b0;
    logic         rst;
    logic         evict_write;
    logic [11:0]  evict_tag;
    logic [127:0] evict_data;
    logic         evict_ready;
    logic [11:0]  lookup_tag;
    logic         lookup_hit;
    logic [127:0] lookup_data;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic         pmem_write;
    logic         pmem_resp;

    typedef struct {
        logic [11:0]  tag;
        logic [127:0] data;
    } entry_t;

    entry_t exp_q[$];
    bit     in_flight;
    int     checks   = 0;
    int     failures = 0;

    victim_writeback_buffer #(
        .DEPTH(4),
        .TAG_WIDTH(12),
        .LINE_WIDTH(128)
    ) dut (
        .clk(clk),
        .rst(rst),
        .evict_write(evict_write),
        .evict_tag(evict_tag),
        .evict_data(evict_data),
        .evict_ready(evict_ready),
        .lookup_tag(lookup_tag),
        .lookup_hit(lookup_hit),
        .lookup_data(lookup_data),
        .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata),
        .pmem_write(pmem_write),
        .pmem_resp(pmem_resp)
    );

    // Free-running clock
    always #5 clk = ~clk;

    function automatic logic [127:0] make_data(input int n);
        logic [15:0] w;
        w = 16'hA500 + 16'(n);
        return {8{w}};
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", name, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_push(input logic [11:0] tag, input logic [127:0] data);
        int     found;
        entry_t e;
        found = -1;
        for (int i = (in_flight ? 1 : 0); i < exp_q.size(); i++) begin
            if (exp_q[i].tag == tag) found = i;
        end
        if (found >= 0) begin
            exp_q[found].data = data;
        end else begin
            e.tag  = tag;
            e.data = data;
            exp_q.push_back(e);
        end
    endfunction

    task automatic applyStimulus(input logic [11:0] tag, input logic [127:0] data);
        bit accept;
        accept = (exp_q.size() < 4);
        checkOutput("evict_ready_pre_push", {127'b0, evict_ready}, {127'b0, accept});
        evict_write = 1'b1;
        evict_tag   = tag;
        evict_data  = data;
        step();
        evict_write = 1'b0;
        if (accept) model_push(tag, data);
    endtask

    task automatic check_lookup(input logic [11:0] tag);
        logic         hit;
        logic [127:0] data;
        hit  = 1'b0;
        data = '0;
        foreach (exp_q[i]) begin
            if (exp_q[i].tag == tag) begin
                hit  = 1'b1;
                data = exp_q[i].data;
            end
        end
        lookup_tag = tag;
        #1;
        checkOutput("lookup_hit", {127'b0, lookup_hit}, {127'b0, hit});
        checkOutput("lookup_data", lookup_data, data);
    endtask

    task automatic wait_write();
        for (int i = 0; i < 20 && !pmem_write; i++) step();
        checkOutput("pmem_write_rise", {127'b0, pmem_write}, 128'd1);
        if (pmem_write) in_flight = 1'b1;
    endtask

    task automatic check_request();
        logic [15:0]  addr;
        logic [127:0] data;
        addr = '0;
        data = '0;
        if (exp_q.size() > 0) begin
            addr = {exp_q[0].tag, 4'h0};
            data = exp_q[0].data;
        end
        checkOutput("pmem_address", {112'b0, pmem_address}, {112'b0, addr});
        checkOutput("pmem_wdata", pmem_wdata, data);
        checkOutput("pmem_write_held", {127'b0, pmem_write}, 128'd1);
    endtask

    task automatic serve_write(input int hold);
        wait_write();
        if (!pmem_write) return;
        repeat (hold) begin
            check_request();
            step();
        end
        check_request();
        pmem_resp = 1'b1;
        step();
        pmem_resp = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        in_flight = 1'b0;
        checkOutput("idle_bubble", {127'b0, pmem_write}, 128'd0);
    endtask

    initial begin
        rst         = 1'b1;
        evict_write = 1'b0;
        evict_tag   = '0;
        evict_data  = '0;
        lookup_tag  = '0;
        pmem_resp   = 1'b0;
        in_flight   = 1'b0;
        step();
        step();

        $display("[TB] reset state");
        checkOutput("reset_evict_ready", {127'b0, evict_ready}, 128'd1);
        checkOutput("reset_pmem_write", {127'b0, pmem_write}, 128'd0);
        checkOutput("reset_pmem_address", {112'b0, pmem_address}, 128'd0);
        checkOutput("reset_pmem_wdata", pmem_wdata, 128'd0);
        check_lookup(12'h123);
        rst = 1'b0;
        step();

        $display("[TB] single writeback");
        applyStimulus(12'h123, make_data(0));
        check_lookup(12'h123);
        serve_write(3);
        checkOutput("empty_evict_ready", {127'b0, evict_ready}, 128'd1);
        check_lookup(12'h123);

        $display("[TB] fill to full and drain in order");
        for (int t = 1; t <= 4; t++) applyStimulus(12'(t), make_data(t));
        checkOutput("full_evict_ready", {127'b0, evict_ready}, 128'd0);
        applyStimulus(12'h005, make_data(5));
        check_lookup(12'h005);
        check_lookup(12'h003);
        for (int t = 1; t <= 4; t++) serve_write(1);

        $display("[TB] overwrite in place");
        applyStimulus(12'h00A, make_data(10));
        applyStimulus(12'h00B, make_data(11));
        applyStimulus(12'h00B, make_data(12));
        checkOutput("overwrite_count", {96'b0, 32'(exp_q.size())}, 128'd2);
        check_lookup(12'h00B);
        serve_write(1);
        serve_write(1);

        $display("[TB] push matching the in-flight entry appends");
        applyStimulus(12'h00A, make_data(10));
        wait_write();
        applyStimulus(12'h00A, make_data(14));
        checkOutput("inflight_evict_ready", {127'b0, evict_ready}, 128'd1);
        check_lookup(12'h00A);
        serve_write(2);
        serve_write(1);

        $display("[TB] pop and push together at full");
        for (int t = 0; t < 4; t++) applyStimulus(12'h011 + 12'(t), make_data(16 + t));
        wait_write();
        checkOutput("full_before_pop", {127'b0, evict_ready}, 128'd0);
        check_request();
        evict_write = 1'b1;
        evict_tag   = 12'h015;
        evict_data  = make_data(21);
        pmem_resp   = 1'b1;
        step();
        pmem_resp = 1'b0;
        void'(exp_q.pop_front());
        in_flight = 1'b0;
        checkOutput("ready_after_pop", {127'b0, evict_ready}, 128'd1);
        step();
        evict_write = 1'b0;
        model_push(12'h015, make_data(21));
        checkOutput("full_again", {127'b0, evict_ready}, 128'd0);
        check_lookup(12'h015);
        for (int t = 0; t < 4; t++) serve_write(1);

        $display("[TB] reset during WRITE");
        for (int t = 0; t < 3; t++) applyStimulus(12'h021 + 12'(t), make_data(32 + t));
        wait_write();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        in_flight = 1'b0;
        checkOutput("rst_pmem_write", {127'b0, pmem_write}, 128'd0);
        checkOutput("rst_evict_ready", {127'b0, evict_ready}, 128'd1);
        for (int t = 0; t < 3; t++) check_lookup(12'h021 + 12'(t));
        pmem_resp = 1'b1;
        step();
        pmem_resp = 1'b0;
        step();
        checkOutput("late_resp_pmem_write", {127'b0, pmem_write}, 128'd0);
        checkOutput("late_resp_evict_ready", {127'b0, evict_ready}, 128'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
